// File: rtl/counter_ud_mod.sv
// Parametrised up/down counter over 0..MAX with load, synchronous clear and
// wrap-or-saturate end-of-range behaviour; tc is combinational on live direction.
module counter_ud_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 255,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == C_MAX);
  assign w_at_zero = (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_sat_nxt   = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = (load_val > C_MAX) ? C_MAX : load_val;
    end else if (en) begin
      // The boundary test uses the exact MAX, so odd moduli never overshoot.
      if (up) begin
        if (!w_at_max) begin
          w_count_nxt = r_count + C_ONE;
        end else if (SATURATE) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_nxt = r_count - C_ONE;
        end else if (SATURATE) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_count_nxt = C_MAX;
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign sat   = r_sat;
  assign tc    = up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter_ud_mod.sv
// Bench for counter_ud_mod: a wrapping MAX=9 instance and a saturating MAX=12
// instance checked against an arithmetic model every cycle plus literal checks.
module tb_counter_ud_mod;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 1;
  logic [3:0] a_lv = '0;
  logic [3:0] a_count;
  logic       a_tc, a_wrap, a_sat;

  logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 1;
  logic [3:0] b_lv = '0;
  logic [3:0] b_count;
  logic       b_tc, b_wrap, b_sat;

  counter_ud_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up(a_up), .count(a_count), .tc(a_tc), .wrap(a_wrap), .sat(a_sat)
  );

  counter_ud_mod #(.WIDTH(4), .MAX(12), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .up(b_up), .count(b_count), .tc(b_tc), .wrap(b_wrap), .sat(b_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    int c;
    bit w;
    bit s;
  } mst_t;

  // Counter semantics as plain integer arithmetic on the range 0..mx.
  function automatic mst_t nxt(input mst_t st, input int mx, input bit satm,
                               input bit c, input bit ld, input int lv,
                               input bit e, input bit u);
    mst_t n;
    int   t;
    n.c = st.c;
    n.w = 1'b0;
    n.s = 1'b0;
    if (c) n.c = 0;
    else if (ld) n.c = (lv > mx) ? mx : lv;
    else if (e) begin
      t = u ? st.c + 1 : st.c - 1;
      if (t < 0 || t > mx) begin
        if (satm) n.s = 1'b1;
        else begin
          n.w = 1'b1;
          n.c = (t + mx + 1) % (mx + 1);
        end
      end else n.c = t;
    end
    return n;
  endfunction

  mst_t ma = '0;
  mst_t mb = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= nxt(ma, 9, 1'b0, a_clr, a_load, int'(a_lv), a_en, a_up);
      mb <= nxt(mb, 12, 1'b1, b_clr, b_load, int'(b_lv), b_en, b_up);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_count", 32'(a_count), 32'(ma.c));
      chk("a_wrap", 32'(a_wrap), 32'(ma.w));
      chk("a_sat", 32'(a_sat), 32'(ma.s));
      chk("a_tc", 32'(a_tc), a_up ? 32'(ma.c == 9) : 32'(ma.c == 0));
      chk("b_count", 32'(b_count), 32'(mb.c));
      chk("b_wrap", 32'(b_wrap), 32'(mb.w));
      chk("b_sat", 32'(b_sat), 32'(mb.s));
      chk("b_tc", 32'(b_tc), b_up ? 32'(mb.c == 12) : 32'(mb.c == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int c, input bit w, input bit t);
    chk({nm, "_count"}, 32'(a_count), 32'(c));
    chk({nm, "_wrap"}, 32'(a_wrap), 32'(w));
    chk({nm, "_sat"}, 32'(a_sat), 32'd0);
    chk({nm, "_tc"}, 32'(a_tc), 32'(t));
  endtask

  task automatic chk_b(input string nm, input int c, input bit s);
    chk({nm, "_count"}, 32'(b_count), 32'(c));
    chk({nm, "_sat"}, 32'(b_sat), 32'(s));
    chk({nm, "_wrap"}, 32'(b_wrap), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk_a("rst_init", 0, 0, 0);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Count up to 6, then assert reset asynchronously between edges.
    a_en = 1; a_up = 1;
    repeat (6) tick();
    chk_a("pre_rst", 6, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_a("resume", k, 0, 0);
    end

    // Up wrap from 3 through 9 back to 0.
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_a("upwrap", (3 + k) % 10, ((3 + k) % 10) == 0, ((3 + k) % 10) == 9);
    end
    tick();
    chk_a("upwrap_end", 1, 0, 0);

    // Load 2 (load beats en), then count down through the wrap.
    a_lv = 4'd2; a_load = 1;
    tick();
    chk_a("ld2", 2, 0, 0);
    a_load = 0; a_up = 0;
    tick();
    chk_a("dn1", 1, 0, 0);
    tick();
    chk_a("dn0", 0, 0, 1);
    tick();
    chk_a("dnwrap", 9, 1, 0);
    a_up = 1;
    #1;
    chk("tc_live_up", 32'(a_tc), 32'd1);
    tick();
    chk_a("dir_flip", 0, 1, 0);

    // Load clamp and priority.
    a_lv = 4'd14; a_load = 1;
    tick();
    chk_a("clamp", 9, 0, 1);
    a_clr = 1; a_lv = 4'd5;
    tick();
    chk_a("clr_wins", 0, 0, 0);
    a_clr = 0;
    tick();
    chk_a("ld_no_inc", 5, 0, 0);
    a_lv = 4'd3;
    tick();
    chk_a("ld3", 3, 0, 0);

    // Enable gating 1,0,0,1.
    a_load = 0;
    a_en = 1; tick(); chk_a("en1", 4, 0, 0);
    a_en = 0; tick(); chk_a("en0a", 4, 0, 0);
    tick(); chk_a("en0b", 4, 0, 0);
    a_en = 1; tick(); chk_a("en1b", 5, 0, 0);
    a_en = 0;

    // Saturating instance at the top boundary.
    b_lv = 4'd11; b_load = 1;
    tick();
    chk_b("s_ld11", 11, 0);
    b_load = 0; b_en = 1; b_up = 1;
    tick(); chk_b("s_up12", 12, 0);
    chk("s_tc12", 32'(b_tc), 32'd1);
    tick(); chk_b("s_hold1", 12, 1);
    tick(); chk_b("s_hold2", 12, 1);

    // Saturating instance at the bottom boundary.
    b_lv = 4'd1; b_load = 1;
    tick(); chk_b("s_ld1", 1, 0);
    b_load = 0; b_up = 0;
    tick(); chk_b("s_dn0", 0, 0);
    tick(); chk_b("s_hold0", 0, 1);
    b_en = 0;
    tick(); chk_b("s_idle", 0, 0);
    b_lv = 4'd15; b_load = 1;
    tick(); chk_b("s_clamp", 12, 0);
    b_load = 0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
